// File: rtl/ibex_rf_wb_queue.sv
// ibex_rf_wb_queue: in-order writeback FIFO in front of the register file write port
// Ports: clk_i/rst_i (sync active-high); req_valid_i/req_ready_o/req_waddr_i/req_wdata_i
// request handshake; rf_stall_i/rf_we_o/rf_waddr_o/rf_wdata_o drain port; raddr_x_i ->
// hazard_x_o/fwd_data_x_o decode lookups; empty_o status; err_o illegal-address pulse.
module ibex_rf_wb_queue #(
  parameter int unsigned DataWidth = 32,
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned Depth     = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [4:0]           req_waddr_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  input  logic                 rf_stall_i,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  output logic                 hazard_a_o,
  output logic                 hazard_b_o,
  output logic [DataWidth-1:0] fwd_data_a_o,
  output logic [DataWidth-1:0] fwd_data_b_o,
  output logic                 empty_o,
  output logic                 err_o
);
  localparam int unsigned PW = $clog2(Depth);
  localparam int unsigned CW = PW + 1;
  logic [4:0]           addr_q [Depth];
  logic [DataWidth-1:0] data_q [Depth];
  logic [PW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic                 full, accept, illegal, push, pop;
  logic                 hit_a, hit_b;
  logic [DataWidth-1:0] dat_a, dat_b;
  logic [PW-1:0]        idx;
  assign empty_o     = cnt_q == '0;
  assign full        = cnt_q == CW'(Depth);
  assign req_ready_o = !full;
  assign accept      = req_valid_i && req_ready_o;
  assign illegal     = RV32E && req_waddr_i[4];
  assign push        = accept && !illegal && req_waddr_i != 5'd0;
  // Reset gates the write so no stale head reaches the register file on the reset edge.
  assign pop         = !empty_o && !rf_stall_i && !rst_i;
  assign rf_we_o     = pop;
  assign rf_waddr_o  = empty_o ? '0 : addr_q[rptr_q];
  assign rf_wdata_o  = empty_o ? '0 : data_q[rptr_q];
  assign wptr_d      = push ? wptr_q + PW'(1) : wptr_q;
  assign rptr_d      = pop ? rptr_q + PW'(1) : rptr_q;
  assign cnt_d       = cnt_q + CW'(push) - CW'(pop);
  assign err_d       = accept && illegal;
  assign err_o       = err_q;
  // Walk from oldest to youngest (k = age offset back from wptr); the youngest match is
  // assigned last and therefore wins.
  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
    dat_a = '0;
    dat_b = '0;
    idx   = '0;
    for (int k = Depth - 1; k >= 0; k--) begin
      idx = wptr_q - PW'(k + 1);
      if (CW'(k) < cnt_q && addr_q[idx] == raddr_a_i) begin
        hit_a = 1'b1;
        dat_a = data_q[idx];
      end
      if (CW'(k) < cnt_q && addr_q[idx] == raddr_b_i) begin
        hit_b = 1'b1;
        dat_b = data_q[idx];
      end
    end
  end
  assign hazard_a_o   = hit_a && raddr_a_i != 5'd0;
  assign hazard_b_o   = hit_b && raddr_b_i != 5'd0;
  assign fwd_data_a_o = hazard_a_o ? dat_a : '0;
  assign fwd_data_b_o = hazard_b_o ? dat_b : '0;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_q[wptr_q] <= req_waddr_i;
      data_q[wptr_q] <= req_wdata_i;
    end
  end
endmodule

// File: doc/ibex_rf_wb_queue.md
# ibex_rf_wb_queue

Writeback queue that sits in front of the register file write port. It accepts register write requests over a valid/ready handshake and buffers them in a small in-order FIFO. It drains one entry per cycle onto the register file write port (`waddr`/`wdata`/`we`) unless that port is stalled. It also gives the decode stage per-read-port pending-write hazard flags, plus forwarding data taken from the youngest matching queued entry.

## Interface
Parameters:
- `DataWidth`, 32, width of write data and forwarded data.
- `RV32E`, 0, when 1 only addresses 0-15 are legal.
- `Depth`, 4, number of queue entries; power of two, at least 2.

Ports:
- `clk_i`  in  1  sole clock; all state updates on its rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `req_valid_i`  in  1  write request valid.
- `req_ready_o`  out  1  queue can accept; equals `!full`.
- `req_waddr_i`  in  5  destination register.
- `req_wdata_i`  in  DataWidth  write data.
- `rf_stall_i`  in  1  register file write port unavailable this cycle.
- `rf_we_o`  out  1  write enable to the register file.
- `rf_waddr_o`  out  5  address at the queue head.
- `rf_wdata_o`  out  DataWidth  data at the queue head.
- `raddr_a_i`, `raddr_b_i`  in  5  decode read addresses.
- `hazard_a_o`, `hazard_b_o`  out  1  a queued write targets that address.
- `fwd_data_a_o`, `fwd_data_b_o`  out  DataWidth  data of the youngest matching entry; 0 when there is no hazard.
- `empty_o`  out  1  queue empty.
- `err_o`  out  1  one-cycle pulse on an accepted illegal-address request.

## Operation
- Storage: `Depth` entries of {addr, data}, plus a write pointer, a read pointer and a count. Pointers are log2(Depth) bits and wrap modulo `Depth`. Count is log2(Depth)+1 bits.
- Handshake:
  - A request is accepted when `req_valid_i && req_ready_o`.
  - Once `req_valid_i` is asserted, it must stay high and its payload must stay stable until the request is accepted.
- Accepted request filtering, in priority order:
  - `RV32E=1` and `req_waddr_i[4]=1`: the request is dropped and `err_o` pulses on the next cycle.
  - `req_waddr_i == 0`: the request is dropped silently.
  - Otherwise: the request is enqueued at the write pointer.
- Drain:
  - `rf_we_o = !empty && !rf_stall_i`.
  - `rf_waddr_o` and `rf_wdata_o` always show the head entry, or 0 when the queue is empty.
  - When `rf_we_o` is high, the head is popped at the clock edge.
- Simultaneous push and pop: count stays the same and both pointers advance. When the queue is full, `req_ready_o` is 0 even if a pop happens that cycle; there is no full-bypass path.
- Hazards:
  - `hazard_x_o` = OR over valid entries of (entry.addr == `raddr_x_i`), forced to 0 when `raddr_x_i == 0`.
  - Entries popped in the current cycle still count as valid.
  - The in-flight request on `req_*` is not checked.
- Forwarding:
  - `fwd_data_x_o` is the data of the youngest matching valid entry, i.e. the one nearest the write pointer.
  - Youngest-first priority search starts at write pointer − 1 and wraps correctly.
- Combinational paths: the hazard and forwarding outputs depend on the read addresses and the stored state only.

## Timing
- Reset values: `req_ready_o=1`, `rf_we_o=0`, `rf_waddr_o=0`, `rf_wdata_o=0`, `hazard_*=0`, `fwd_*=0`, `empty_o=1`, `err_o=0`. Pointers and count are 0.
- Reset applied mid-operation discards every queued entry; the outputs take their reset values in the cycle after the reset edge. No write is issued to the register file during or after that reset edge.
- Latency: a request accepted at edge N appears on `rf_we_o` in the cycle following edge N, when `rf_stall_i=0`. There is no same-cycle pass-through.
- Throughput: one accept and one drain per cycle, sustained indefinitely when there are no stalls.
- `rf_stall_i` is sampled combinationally. While it is high, the head is held, and `rf_waddr_o`/`rf_wdata_o` keep their values.
- `err_o` is registered: it is high for exactly one cycle after each accepted illegal request.

## Test plan
- Basic write:
  - Stimulus: after reset, push {addr 5, data 0xDEADBEEF} with `rf_stall_i=0`.
  - Required response: next cycle `rf_we_o=1`, `rf_waddr_o=5`, `rf_wdata_o=0xDEADBEEF`; the cycle after that `empty_o=1`.
- Fill and back-pressure:
  - Stimulus: hold `rf_stall_i=1` and push addresses 1, 2, 3, 4 (`Depth`=4).
  - Required response: `req_ready_o=0` after the fourth accept. A fifth request is held.
  - Stimulus: release the stall.
  - Required response: writes go to 1, 2, 3, 4 in order on consecutive cycles, and the fifth request is accepted one cycle after the release.
- Forwarding priority:
  - Stimulus: stall, then queue {7, 0x11} and {7, 0x22}; set `raddr_a_i=7`.
  - Required response: `hazard_a_o=1`, `fwd_data_a_o=0x22`.
  - Stimulus: set `raddr_b_i=0`.
  - Required response: `hazard_b_o=0`.
- Wrap-around:
  - Stimulus: push and drain 6 entries, then stall and queue {9, 0xA}, {9, 0xB}, straddling the pointer wrap.
  - Required response: `fwd_data_a_o=0xB` for `raddr_a_i=9`.
- Filtering:
  - Stimulus: push x0 with data 0x55.
  - Required response: accepted, nothing queued, no `rf_we_o`.
  - Stimulus: with `RV32E=1`, push addr 20.
  - Required response: accepted, dropped, `err_o` high for one cycle.
- Reset mid-operation:
  - Stimulus: queue 3 entries under stall, then assert `rst_i` for one cycle.
  - Required response: `empty_o=1`, `rf_we_o=0`, `hazard_*=0` afterwards, with no spurious write.
